fadder_pipe_top: RTL and testbench
==================================

// Module: fadder_pipe_top
//
// PURPOSE
//   Parametrised, pipelined adder/subtractor/accumulator with valid/ready flow control.
//   Successor to the single-stage full adder: configurable width and pipeline depth,
//   optional saturation, a running-accumulate mode, and backpressure from downstream.
//   Sits between an operand producer and a result consumer on the datapath.
//
// PARAMETERS
//   DATA_WIDTH  8  Operand/result width in bits (>= 2)
//   NUM_STAGES  2  Pipeline registers from accept to output (1..4); sets latency
//   SATURATE    0  1: clamp add/sub results instead of wrapping (accumulate never clamps)
//
// PORTS
//   clk        in   1           Clock, rising edge
//   reset      in   1           Asynchronous reset, active-high
//   en         in   1           Block enable; 0 freezes the whole block
//   op         in   2           00 sub, 01 add, 10 accumulate, 11 accumulator load
//   vld_in     in   1           Input operands valid
//   rdy_in     out  1           Block can accept operands this cycle
//   carry_in   in   1           Carry in; used by add only
//   op_a       in   DATA_WIDTH  Operand A
//   op_b       in   DATA_WIDTH  Operand B; ignored by op 10/11
//   vld_out    out  1           Result valid
//   rdy_out    in   1           Downstream accepts result this cycle
//   carry_out  out  1           Add: carry; sub: borrow (b>a); acc: wrap carry; load: 0
//   overflow   out  1           1 when the result was clamped (SATURATE=1 only, else 0)
//   data_out   out  DATA_WIDTH  Result
//
// BEHAVIOUR
//   - Reset (async assert, any cycle, including mid-operation):
//     all stage valids 0, all stage data 0, accumulator 0.
//     Outputs: vld_out=0, carry_out=0, overflow=0, data_out=0.
//     rdy_in follows its equation (no state is held).
//   - advance = en & (~vld_out | rdy_out); rdy_in = advance.
//     Input transfer = vld_in & rdy_in. Output transfer = vld_out & rdy_out.
//   - Stage 1 loads the computed result on a transfer.
//     On advance with no transfer, stage 1 valid clears.
//     Stage k+1 loads stage k on every advance; all stages hold when advance=0.
//   - Latency: a result appears on vld_out exactly NUM_STAGES cycles after its transfer
//     when unstalled. One result per cycle sustained when rdy_out=1.
//   - Ordering is preserved; no result is dropped or duplicated under any rdy_out pattern.
//   - Stall: vld_out=1 & rdy_out=0 freezes every stage; data_out/carry_out/overflow stable.
//   - en=0: same freeze as a stall and rdy_in=0. Accumulator holds.
//     Resumes intact when en returns to 1.
//   - Arithmetic (evaluated at transfer, widths W=DATA_WIDTH, result W+1 internally):
//     sub : data=(a-b) mod 2^W, carry_out=(b>a); SATURATE: if borrow, data=0, overflow=1
//     add : {carry_out,data}=a+b+carry_in; SATURATE: if carry, data=all ones, overflow=1
//     acc : {carry_out,data}=acc+a; acc<=data (wraps); overflow=0
//     load: data=a, acc<=a, carry_out=0, overflow=0
//   - The accumulator updates only on a transfer with op 10/11.
//     Back-to-back acc transfers chain correctly: each uses the updated value.
//   - op and carry_in are sampled only on a transfer; they are don't-care otherwise.
//
// TESTING
//   1 W=8,S=2: add a=200,b=100,ci=1 -> 2 cycles later data=45,carry=1,vld_out=1
//   2 SATURATE=1: sub a=5,b=9 -> data=0,carry=1,overflow=1;
//     add 250+10 -> data=255,overflow=1
//   3 load 10, then acc 250, 3 back-to-back -> data 10, 4 (carry=1), 7;
//     acc=7 afterwards
//   4 Stream 8 adds with rdy_out toggling 1,0,0,1 pattern -> 8 results, in order, no
//     duplicates; outputs stable while stalled; rdy_in=0 while vld_out&~rdy_out
//   5 en=0 for 3 cycles mid-stream -> rdy_in=0, stage contents and acc unchanged,
//     stream completes correctly after en=1
//   6 Assert reset with 2 results in flight -> vld_out=0, data_out=0 immediately
//     (async); first acc after reset returns 0+a

Source files
------------

// File: rtl/fadder_pipe_top.sv
// fadder_pipe_top: pipelined add / subtract / accumulate unit with valid/ready
// flow control. A result is computed combinationally when operands are accepted
// and then travels through NUM_STAGES registers before reaching the outputs.
// The whole pipeline advances as one unit, so a stalled output freezes every stage.
module fadder_pipe_top #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            op,
  input  logic                  vld_in,
  output logic                  rdy_in,
  input  logic                  carry_in,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  vld_out,
  input  logic                  rdy_out,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Result bundle layout: {overflow, carry, data}
  localparam int RW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  logic                  w_advance;
  logic                  w_xfer;
  logic [RW-1:0]         w_res;
  logic [DATA_WIDTH-1:0] r_acc;

  logic                  r_vld_p   [NUM_STAGES];
  logic                  r_carry_p [NUM_STAGES];
  logic                  r_ovf_p   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] r_data_p  [NUM_STAGES];

  // Subtract; the borrow is the ninth bit of the widened difference (b > a).
  // With saturation a borrow clamps the result to zero.
  function automatic logic [RW-1:0] f_sub(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (SATURATE && d[DATA_WIDTH])
      return {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
    return {1'b0, d};
  endfunction

  // Add with carry-in; with saturation a carry clamps the result to all ones.
  function automatic logic [RW-1:0] f_add(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b,
                                          input logic                  ci);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, ci};
    if (SATURATE && s[DATA_WIDTH])
      return {1'b1, 1'b1, {DATA_WIDTH{1'b1}}};
    return {1'b0, s};
  endfunction

  // Accumulate always wraps; the carry reports the wrap.
  function automatic logic [RW-1:0] f_acc(input logic [DATA_WIDTH-1:0] acc,
                                          input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, acc} + {1'b0, a};
    return {1'b0, s};
  endfunction

  // The pipeline moves only when enabled and the output slot is empty or draining.
  assign w_advance = en & (~r_vld_p[NUM_STAGES-1] | rdy_out);
  assign rdy_in    = w_advance;
  assign w_xfer    = vld_in & w_advance;

  // Operation decode: result computed from the live operands and the accumulator.
  always_comb begin
    w_res = '0;
    case (op_e'(op))
      OP_SUB:  w_res = f_sub(op_a, op_b);
      OP_ADD:  w_res = f_add(op_a, op_b, carry_in);
      OP_ACC:  w_res = f_acc(r_acc, op_a);
      OP_LOAD: w_res = {2'b00, op_a};
      default: w_res = '0;
    endcase
  end

  // Accumulator: updated only by an accepted accumulate or load, so back-to-back
  // accumulates see each other's results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_acc <= '0;
    else if (w_xfer && op[1])
      r_acc <= w_res[DATA_WIDTH-1:0];
  end

  // Stage p0 captures a new result on transfer; later stages shift on every advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_vld_p[k]   <= 1'b0;
        r_carry_p[k] <= 1'b0;
        r_ovf_p[k]   <= 1'b0;
        r_data_p[k]  <= '0;
      end
    end else if (w_advance) begin
      r_vld_p[0] <= w_xfer;
      if (w_xfer) begin
        r_ovf_p[0]   <= w_res[RW-1];
        r_carry_p[0] <= w_res[DATA_WIDTH];
        r_data_p[0]  <= w_res[DATA_WIDTH-1:0];
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_vld_p[k]   <= r_vld_p[k-1];
        r_carry_p[k] <= r_carry_p[k-1];
        r_ovf_p[k]   <= r_ovf_p[k-1];
        r_data_p[k]  <= r_data_p[k-1];
      end
    end
  end

  assign vld_out   = r_vld_p[NUM_STAGES-1];
  assign carry_out = r_carry_p[NUM_STAGES-1];
  assign overflow  = r_ovf_p[NUM_STAGES-1];
  assign data_out  = r_data_p[NUM_STAGES-1];

endmodule

// File: tb/tb_fadder_pipe_top.sv
// Bench for fadder_pipe_top: a wrapping instance and a saturating instance share
// all inputs; a scoreboard queue holds the expected result for both per transfer.
module tb_fadder_pipe_top;

  logic       clk, reset, en, vld_in, rdy_out, carry_in;
  logic [1:0] op;
  logic [7:0] op_a, op_b;
  logic       rdy_in0, vld_out0, carry_out0, overflow0;
  logic       rdy_in1, vld_out1, carry_out1, overflow1;
  logic [7:0] data_out0, data_out1;

  fadder_pipe_top #(.DATA_WIDTH(8), .NUM_STAGES(2), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .op(op), .vld_in(vld_in), .rdy_in(rdy_in0),
    .carry_in(carry_in), .op_a(op_a), .op_b(op_b), .vld_out(vld_out0),
    .rdy_out(rdy_out), .carry_out(carry_out0), .overflow(overflow0), .data_out(data_out0));

  fadder_pipe_top #(.DATA_WIDTH(8), .NUM_STAGES(2), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .op(op), .vld_in(vld_in), .rdy_in(rdy_in1),
    .carry_in(carry_in), .op_a(op_a), .op_b(op_b), .vld_out(vld_out1),
    .rdy_out(rdy_out), .carry_out(carry_out1), .overflow(overflow1), .data_out(data_out1));

  typedef struct {
    logic [7:0] d0; logic c0;
    logic [7:0] d1; logic c1; logic o1;
    bit lat; int cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mode = 0;
  int         pc = 0;
  logic [7:0] m_acc = 8'd0;
  logic [3:0] pat = 4'b1001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d0, input logic c0,
                              input logic [7:0] d1, input logic c1, input logic o1);
    exp_t e;
    e.d0 = d0; e.c0 = c0; e.d1 = d1; e.c1 = c1; e.o1 = o1; e.lat = 1'b0; e.cyc = 0;
    return e;
  endfunction

  // Reference arithmetic for stream stimulus (directed cases use literal expectations)
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    logic [8:0] s;
    exp_t e;
    e = mk(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    case (o)
      2'b00: begin
        s = {1'b0, a} - {1'b0, b};
        e.d0 = s[7:0]; e.c0 = (b > a);
        e.d1 = e.c0 ? 8'h00 : s[7:0]; e.c1 = e.c0; e.o1 = e.c0;
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.d0 = s[7:0]; e.c0 = s[8];
        e.d1 = s[8] ? 8'hFF : s[7:0]; e.c1 = s[8]; e.o1 = s[8];
      end
      2'b10: begin
        s = {1'b0, m_acc} + {1'b0, a};
        e.d0 = s[7:0]; e.c0 = s[8]; e.d1 = s[7:0]; e.c1 = s[8];
      end
      default: begin
        e.d0 = a; e.d1 = a;
      end
    endcase
    return e;
  endfunction

  // Present one operand set and hold it until accepted; push the expectation on acceptance
  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input exp_t e);
    int n;
    n = 0;
    @(posedge clk); #1;
    op = o; op_a = a; op_b = b; carry_in = ci; vld_in = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_in0) begin
        e.cyc = cyc;
        sb.push_back(e);
        if (o[1]) m_acc = e.d0;
        break;
      end
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got rdy_in=0 for %0d cycles expected 1", n);
        break;
      end
    end
  endtask

  task automatic stream(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
    issue(o, a, b, ci, model(o, a, b, ci));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    vld_in = 1'b0;
  endtask

  // Downstream ready / enable driver: 0 = free-running, 1 = 1,0,0,1 ready pattern,
  // 2 = enable dropped for three cycles (ready follows enable)
  initial begin
    rdy_out = 1'b1; en = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1: begin rdy_out = pat[pc % 4]; en = 1'b1; end
        2: begin en = !(pc >= 3 && pc < 6); rdy_out = en; end
        default: begin rdy_out = 1'b1; en = 1'b1; end
      endcase
      pc++;
    end
  end

  // Monitor: checks ready, stall stability and pops the scoreboard on each output transfer
  logic       prev_hold = 1'b0;
  logic [7:0] pd0, pd1;
  logic       pc0, pc1, po1;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      chk1("rdy_in0", rdy_in0, en & (~vld_out0 | rdy_out));
      chk1("rdy_in1", rdy_in1, en & (~vld_out1 | rdy_out));
      if (prev_hold) begin
        chk1("hold_vld", vld_out0, 1'b1);
        chk8("hold_data0", data_out0, pd0);
        chk1("hold_carry0", carry_out0, pc0);
        chk8("hold_data1", data_out1, pd1);
        chk1("hold_carry1", carry_out1, pc1);
        chk1("hold_ovf1", overflow1, po1);
      end
      if (vld_out0 && rdy_out) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_output: got data=%0d expected no result", data_out0);
        end else begin
          e = sb.pop_front();
          chk8("data0", data_out0, e.d0);
          chk1("carry0", carry_out0, e.c0);
          chk1("ovf0", overflow0, 1'b0);
          chk1("vld1", vld_out1, 1'b1);
          chk8("data1", data_out1, e.d1);
          chk1("carry1", carry_out1, e.c1);
          chk1("ovf1", overflow1, e.o1);
          if (e.lat) chk8("latency", 8'(cyc - e.cyc), 8'd2);
        end
      end else if (!vld_out0) begin
        chk1("vld1_idle", vld_out1, 1'b0);
      end
      prev_hold = vld_out0 & ~(en & rdy_out);
      pd0 = data_out0; pc0 = carry_out0;
      pd1 = data_out1; pc1 = carry_out1; po1 = overflow1;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; vld_in = 1'b0; op = 2'b00; op_a = 8'd0; op_b = 8'd0; carry_in = 1'b0;
    #3;
    chk1("rst_vld0", vld_out0, 1'b0);
    chk8("rst_data0", data_out0, 8'd0);
    chk1("rst_carry0", carry_out0, 1'b0);
    chk1("rst_ovf1", overflow1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Add with carry in, latency from acceptance to output
    e = mk(8'd45, 1'b1, 8'd255, 1'b1, 1'b1);
    e.lat = 1'b1;
    issue(2'b01, 8'd200, 8'd100, 1'b1, e);
    drain();

    // Subtract / add boundaries, saturating and not
    issue(2'b00, 8'd5,   8'd9,  1'b0, mk(8'd252, 1'b1, 8'd0,   1'b1, 1'b1));
    issue(2'b01, 8'd250, 8'd10, 1'b0, mk(8'd4,   1'b1, 8'd255, 1'b1, 1'b1));
    issue(2'b00, 8'd9,   8'd5,  1'b1, mk(8'd4,   1'b0, 8'd4,   1'b0, 1'b0));
    issue(2'b00, 8'd7,   8'd7,  1'b0, mk(8'd0,   1'b0, 8'd0,   1'b0, 1'b0));
    issue(2'b01, 8'd255, 8'd0,  1'b1, mk(8'd0,   1'b1, 8'd255, 1'b1, 1'b1));
    issue(2'b01, 8'd254, 8'd0,  1'b1, mk(8'd255, 1'b0, 8'd255, 1'b0, 1'b0));

    // Load then back-to-back accumulates (operand B ignored), then read back with +0
    issue(2'b11, 8'd10,  8'd99, 1'b1, mk(8'd10, 1'b0, 8'd10, 1'b0, 1'b0));
    issue(2'b10, 8'd250, 8'd55, 1'b1, mk(8'd4,  1'b1, 8'd4,  1'b1, 1'b0));
    issue(2'b10, 8'd3,   8'd0,  1'b0, mk(8'd7,  1'b0, 8'd7,  1'b0, 1'b0));
    issue(2'b10, 8'd0,   8'd0,  1'b0, mk(8'd7,  1'b0, 8'd7,  1'b0, 1'b0));
    drain();

    // Stream of adds under a 1,0,0,1 ready pattern
    mode = 1; pc = 0;
    for (int i = 0; i < 8; i++)
      stream(2'b01, 8'(i * 37 + 20), 8'(i * 11 + 1), i[0]);
    drain();

    // Enable dropped mid-stream, with accumulates in the stream
    mode = 2; pc = 0;
    stream(2'b11, 8'd100, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      stream(i[0] ? 2'b10 : 2'b01, 8'(i * 23 + 60), 8'(i * 5), 1'b1);
    drain();
    mode = 0;

    // Asynchronous reset with two results in flight
    stream(2'b01, 8'd1, 8'd2, 1'b0);
    stream(2'b01, 8'd3, 8'd4, 1'b0);
    @(posedge clk); #1;
    vld_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk1("async_vld0", vld_out0, 1'b0);
    chk8("async_data0", data_out0, 8'd0);
    chk1("async_vld1", vld_out1, 1'b0);
    chk8("async_data1", data_out1, 8'd0);
    sb.delete();
    m_acc = 8'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(2'b10, 8'd7, 8'd0, 1'b0, mk(8'd7, 1'b0, 8'd7, 1'b0, 1'b0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
